// File: rtl/exmu_sequencer.sv
// rtl/exmu_sequencer.sv - ExMU cache/memory request sequencer; optional memory-wait watchdog via EXMU_SEQ_TIMEOUT_EN
module exmu_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic        i_EXT_readReq,
  input  logic        i_EXT_writeReq,
  input  logic        i_EXT_flushReq,
  output logic        o_EXT_readDone,
  output logic        o_EXT_writeDone,
  output logic        o_EXT_flushDone,
  input  logic        i_ExMU_readInCache,
  input  logic        i_ExMU_writeInCache,
  output logic        o_CU_ExMU_readCache,
  output logic        o_CU_ExMU_writeCache,
  output logic        o_CU_ExMU_readWriteID,
  output logic        o_CU_ExMU_readPoint,
  output logic        o_CU_ExMU_writePoint,
  output logic        o_CU_ExMU_writeMem,
  output logic        o_MEM_readReq,
  input  logic        i_MEM_readValid,
  output logic        o_MEM_writeReq,
  input  logic        i_MEM_writeAck,
  output logic [31:0] o_status
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL_ID   = 3'd1,
    FETCH    = 3'd2,
    FILL     = 3'd3,
    SERVE    = 3'd4,
    FLUSH_LD = 3'd5,
    FLUSH_WR = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t      state;
  logic        op_write;     // operation in flight is a write (read otherwise)
  logic        fetch_after;  // current flush is the eviction step of a dirty write miss
  logic        dirty;
  logic        rr_write;     // 1: write wins the next read/write contention
  logic [11:0] hit_cnt;
  logic [11:0] miss_cnt;
  logic        err_bit;
  logic        grant_write;

  // Write is granted when requested and either favoured or uncontested
  assign grant_write = i_EXT_writeReq && (rr_write || !i_EXT_readReq);

`ifdef EXMU_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        wait_expired;
  logic        err;

  // Watchdog fires on the last permitted wait cycle
  assign wait_expired = (wait_cnt == (TIMEOUT_CYCLES - 16'd1));
  assign err_bit      = err;
`else
  logic unused_timeout_cfg;

  // Without the watchdog the limit has no effect and the error bit never sets
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign err_bit            = 1'b0;
`endif

  // Status word is a direct view of sequencer state
  assign o_status = {miss_cnt, hit_cnt, 1'b0, state, 1'b0, err_bit, dirty, (state != IDLE)};

  // Sequencer: state, unit controls, memory handshakes, dirty flag and counters
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      state                 <= IDLE;
      op_write              <= 1'b0;
      fetch_after           <= 1'b0;
      dirty                 <= 1'b0;
      rr_write              <= 1'b1;
      hit_cnt               <= 12'd0;
      miss_cnt              <= 12'd0;
      o_EXT_readDone        <= 1'b0;
      o_EXT_writeDone       <= 1'b0;
      o_EXT_flushDone       <= 1'b0;
      o_CU_ExMU_readCache   <= 1'b0;
      o_CU_ExMU_writeCache  <= 1'b0;
      o_CU_ExMU_readWriteID <= 1'b0;
      o_CU_ExMU_readPoint   <= 1'b0;
      o_CU_ExMU_writePoint  <= 1'b0;
      o_CU_ExMU_writeMem    <= 1'b0;
      o_MEM_readReq         <= 1'b0;
      o_MEM_writeReq        <= 1'b0;
`ifdef EXMU_SEQ_TIMEOUT_EN
      wait_cnt              <= 16'd0;
      err                   <= 1'b0;
`endif
    end else begin
      // single-cycle controls default low; memory requests hold their value
      o_EXT_readDone        <= 1'b0;
      o_EXT_writeDone       <= 1'b0;
      o_EXT_flushDone       <= 1'b0;
      o_CU_ExMU_readCache   <= 1'b0;
      o_CU_ExMU_writeCache  <= 1'b0;
      o_CU_ExMU_readWriteID <= 1'b0;
      o_CU_ExMU_readPoint   <= 1'b0;
      o_CU_ExMU_writePoint  <= 1'b0;
      o_CU_ExMU_writeMem    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_EXT_flushReq) begin
            op_write    <= 1'b0;
            fetch_after <= 1'b0;
            if (dirty) begin
              state              <= FLUSH_LD;
              o_CU_ExMU_writeMem <= 1'b1;
            end else begin
              state           <= DONE;
              o_EXT_flushDone <= 1'b1;
            end
          end else if (grant_write) begin
            op_write <= 1'b1;
            rr_write <= 1'b0;
            if (i_ExMU_writeInCache) begin
              state                <= SERVE;
              o_CU_ExMU_writePoint <= 1'b1;
              dirty                <= 1'b1;
              hit_cnt              <= hit_cnt + 12'd1;
            end else if (dirty) begin
              state              <= FLUSH_LD;
              o_CU_ExMU_writeMem <= 1'b1;
              fetch_after        <= 1'b1;
            end else begin
              state                 <= SEL_ID;
              o_CU_ExMU_readWriteID <= 1'b1;
              miss_cnt              <= miss_cnt + 12'd1;
            end
          end else if (i_EXT_readReq) begin
            op_write <= 1'b0;
            rr_write <= 1'b1;
            if (i_ExMU_readInCache) begin
              state               <= SERVE;
              o_CU_ExMU_readPoint <= 1'b1;
              hit_cnt             <= hit_cnt + 12'd1;
            end else begin
              state    <= SEL_ID;
              miss_cnt <= miss_cnt + 12'd1;
            end
          end
        end
        SEL_ID: begin
          state         <= FETCH;
          o_MEM_readReq <= 1'b1;
`ifdef EXMU_SEQ_TIMEOUT_EN
          wait_cnt      <= 16'd0;
`endif
        end
        FETCH: begin
          if (i_MEM_readValid) begin
            o_MEM_readReq <= 1'b0;
            state         <= FILL;
            if (op_write) begin
              o_CU_ExMU_writeCache <= 1'b1;
              dirty                <= 1'b0;
            end else begin
              o_CU_ExMU_readCache <= 1'b1;
            end
          end
`ifdef EXMU_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            o_MEM_readReq   <= 1'b0;
            err             <= 1'b1;
            state           <= DONE;
            o_EXT_writeDone <= op_write;
            o_EXT_readDone  <= !op_write;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        FILL: begin
          state <= SERVE;
          if (op_write) begin
            o_CU_ExMU_writePoint <= 1'b1;
            dirty                <= 1'b1;
          end else begin
            o_CU_ExMU_readPoint <= 1'b1;
          end
        end
        SERVE: begin
          state           <= DONE;
          o_EXT_writeDone <= op_write;
          o_EXT_readDone  <= !op_write;
        end
        FLUSH_LD: begin
          state          <= FLUSH_WR;
          o_MEM_writeReq <= 1'b1;
`ifdef EXMU_SEQ_TIMEOUT_EN
          wait_cnt       <= 16'd0;
`endif
        end
        FLUSH_WR: begin
          if (i_MEM_writeAck) begin
            o_MEM_writeReq <= 1'b0;
            dirty          <= 1'b0;
            fetch_after    <= 1'b0;
            if (fetch_after) begin
              state                 <= SEL_ID;
              o_CU_ExMU_readWriteID <= 1'b1;
              miss_cnt              <= miss_cnt + 12'd1;
            end else begin
              state           <= DONE;
              o_EXT_flushDone <= 1'b1;
            end
          end
`ifdef EXMU_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            o_MEM_writeReq  <= 1'b0;
            err             <= 1'b1;
            state           <= DONE;
            fetch_after     <= 1'b0;
            o_EXT_writeDone <= fetch_after;
            o_EXT_flushDone <= !fetch_after;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exmu_sequencer.md
EXMU_SEQUENCER -- requirements
Module: exmu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, giving the memory-wait watchdog limit in cycles.
REQ-002 SHALL have port i_SYSTEM_clk  in  1  the single clock; all flops are rising-edge.
REQ-003 SHALL have port i_SYSTEM_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_EXT_readReq / i_EXT_writeReq / i_EXT_flushReq  in  1 each  level requests, held until the matching done pulse.
REQ-005 SHALL have ports o_EXT_readDone / o_EXT_writeDone / o_EXT_flushDone  out  1 each  one-cycle completion pulses.
REQ-006 SHALL have ports i_ExMU_readInCache / i_ExMU_writeInCache  in  1 each  cache-hit flags from the extension memory unit.
REQ-007 SHALL have ports o_CU_ExMU_readCache, o_CU_ExMU_writeCache, o_CU_ExMU_readWriteID, o_CU_ExMU_readPoint, o_CU_ExMU_writePoint, o_CU_ExMU_writeMem  out  1 each  registered unit controls.
REQ-008 SHALL have ports o_MEM_readReq  out  1, i_MEM_readValid  in  1, o_MEM_writeReq  out  1, i_MEM_writeAck  in  1  block-memory handshake.
REQ-009 SHALL have port o_status  out  32  [0] busy, [1] dirty, [2] timeout error (sticky), [7:4] state code, [19:8] hit count, [31:20] miss count.

Function
REQ-010 SHALL implement states IDLE(0), SEL_ID(1), FETCH(2), FILL(3), SERVE(4), FLUSH_LD(5), FLUSH_WR(6), DONE(7); o_status[7:4] = code.
REQ-011 SHALL drive all o_CU_* and o_MEM_* from flops, deasserted in every state not listed for them.
REQ-012 SHALL arbitrate in IDLE: flush > write > read, except write and read alternate (round-robin flag) when both pending and no flush.
REQ-013 SHALL, on a hit (readInCache for read, writeInCache for write) sampled in IDLE at cycle N, pulse readPoint (read) or writePoint (write) at N+1 and the done pulse at N+2.
REQ-014 SHALL, on a write miss with dirty=1, first execute the flush sequence (REQ-017), then the fetch sequence, without asserting flushDone.
REQ-015 SHALL, on a miss, enter SEL_ID holding readWriteID = 1 for write, 0 for read, for exactly one cycle, then FETCH.
REQ-016 SHALL in FETCH hold o_MEM_readReq=1 until i_MEM_readValid=1; in that same cycle drop readReq and, next cycle (FILL), pulse readCache (read) or writeCache (write) for one cycle, then SERVE as in REQ-013.
REQ-017 SHALL flush by pulsing writeMem one cycle (FLUSH_LD), then holding o_MEM_writeReq=1 in FLUSH_WR until i_MEM_writeAck=1, then clearing dirty.
REQ-018 SHALL on flush request with dirty=0 pulse flushDone at N+1 without memory traffic.
REQ-019 SHALL set dirty on every writePoint pulse; writeCache fill SHALL clear dirty.
REQ-020 SHALL increment hit count on each hit-path SERVE and miss count on each SEL_ID entry, 12-bit wrapping.
REQ-021 SHALL ignore request changes while not IDLE; DONE returns to IDLE the next cycle, so back-to-back requests are spaced by one idle cycle minimum.
REQ-022 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-023 SHALL on i_SYSTEM_rst=0 asynchronously force state IDLE, all o_CU_*, o_MEM_*, o_EXT_* to 0, dirty 0, counters 0, error 0, round-robin flag to favour write.
REQ-024 SHALL abandon any in-flight memory handshake on reset; no done pulse is produced for it.

Configuration
REQ-025 SHALL, when EXMU_SEQ_TIMEOUT_EN is defined, count cycles in FETCH/FLUSH_WR; reaching TIMEOUT_CYCLES SHALL drop the request, set status[2], pulse the pending done, and return to IDLE.
REQ-026 SHALL, when EXMU_SEQ_TIMEOUT_EN is undefined, omit the counter, wait indefinitely, and tie status[2] to 0.

Verification
REQ-027 SHALL cover read hit: readReq=1, readInCache=1 at N -> readPoint at N+1, readDone at N+2, hit count 1.
REQ-028 SHALL cover read miss: readInCache=0, readValid after 3 cycles -> readWriteID=0 one cycle, readReq 3 cycles, readCache pulse, readPoint, readDone; miss count 1.
REQ-029 SHALL cover dirty write miss: write hit then write miss -> writeMem, writeReq until ack, writeCache fill, writePoint, writeDone; dirty ends 1.
REQ-030 SHALL cover simultaneous readReq and writeReq with hits twice -> write served first, then read.
REQ-031 SHALL cover reset asserted mid-FETCH -> all outputs 0 immediately, state IDLE, no done pulse.
REQ-032 SHALL cover, with EXMU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no readValid -> readReq drops after 8 cycles, status[2]=1, readDone pulses.
